pacman_score_keeper: RTL

//  Downstream of pacman_movement: consumes its single-cycle event pulses (pellet, power pellet, ghost eaten).

---
 rtl/pacman_score_keeper_pkg.sv | 57 +++++
 rtl/pacman_score_keeper_if.sv | 25 ++
 rtl/pacman_score_keeper_bcd_digit_add.sv | 22 ++
 rtl/pacman_score_keeper.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_score_keeper_pkg.sv
// Shared definitions for the score keeper: event codes, FSM states,
// packed-BCD point values and small encoding helpers.
package pacman_score_keeper_pkg;

    localparam int DIGITS_DEF     = 4;
    localparam int LIFE_DIGIT_DEF = 5;
    localparam int QDEPTH_DEF     = 4;

    // Ghost codes carry the combo level in their two LSBs.
    typedef enum logic [2:0] {
        EV_PELLET = 3'd0,
        EV_POWER  = 3'd1,
        EV_GHOST0 = 3'd4,
        EV_GHOST1 = 3'd5,
        EV_GHOST2 = 3'd6,
        EV_GHOST3 = 3'd7
    } ev_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ADD   = 2'd2,
        ST_CHECK = 2'd3
    } state_e;

    localparam logic [15:0] PTS_PELLET = 16'h0010;
    localparam logic [15:0] PTS_POWER  = 16'h0050;
    localparam logic [15:0] PTS_GHOST0 = 16'h0200;
    localparam logic [15:0] PTS_GHOST1 = 16'h0400;
    localparam logic [15:0] PTS_GHOST2 = 16'h0800;
    localparam logic [15:0] PTS_GHOST3 = 16'h1600;

    function automatic logic [15:0] points_bcd(input ev_code_e code);
        case (code)
            EV_PELLET: points_bcd = PTS_PELLET;
            EV_POWER:  points_bcd = PTS_POWER;
            EV_GHOST0: points_bcd = PTS_GHOST0;
            EV_GHOST1: points_bcd = PTS_GHOST1;
            EV_GHOST2: points_bcd = PTS_GHOST2;
            EV_GHOST3: points_bcd = PTS_GHOST3;
            default:   points_bcd = 16'h0000;
        endcase
    endfunction

    function automatic ev_code_e ghost_code(input logic [1:0] combo);
        ghost_code = ev_code_e'({1'b1, combo});
    endfunction

    function automatic logic [1:0] combo_next(input logic [1:0] combo);
        if (combo == 2'd3) begin
            combo_next = 2'd3;
        end else begin
            combo_next = combo + 2'd1;
        end
    endfunction

endpackage

// File: rtl/pacman_score_keeper_if.sv
// Event pulses from pacman_movement in, score/high-score display and status out.
interface pacman_score_keeper_if #(
    parameter int DIGITS = 4
);
    logic                    game_start;
    logic                    pellet_eaten;
    logic                    power_eaten;
    logic                    ghost_eaten;
    logic                    game_over;
    logic [4*DIGITS-1:0]     score_bcd;
    logic [4*DIGITS-1:0]     hi_bcd;
    logic                    busy;
    logic                    extra_life;
    logic                    q_overflow;

    modport master (
        output game_start, pellet_eaten, power_eaten, ghost_eaten, game_over,
        input  score_bcd, hi_bcd, busy, extra_life, q_overflow
    );

    modport slave (
        input  game_start, pellet_eaten, power_eaten, ghost_eaten, game_over,
        output score_bcd, hi_bcd, busy, extra_life, q_overflow
    );
endinterface

// File: rtl/pacman_score_keeper_bcd_digit_add.sv
// One packed-BCD digit adder with decimal carry (+6 correction above 9).
module pacman_score_keeper_bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] raw_s;

    // Binary sum, then fold back into 0..9 with a carry.
    always_comb begin
        raw_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (raw_s > 5'd9) begin
            sum  = raw_s[3:0] + 4'd6;
            cout = 1'b1;
        end else begin
            sum  = raw_s[3:0];
            cout = 1'b0;
        end
    end
endmodule

// File: rtl/pacman_score_keeper.sv
// Queues game event pulses and adds their points into a packed-BCD score one
// digit per cycle; tracks the session high score and the extra-life threshold.
module pacman_score_keeper
    import pacman_score_keeper_pkg::*;
#(
    parameter int DIGITS     = DIGITS_DEF,
    parameter int LIFE_DIGIT = LIFE_DIGIT_DEF,
    parameter int QDEPTH     = QDEPTH_DEF     // power of two, >= 2
) (
    input  logic                  board_clk,
    input  logic                  Reset,
    pacman_score_keeper_if.slave  sk
);
    localparam int SCORE_W = 4 * DIGITS;
    localparam int PTR_W   = $clog2(QDEPTH);
    localparam int CNT_W   = $clog2(QDEPTH + 1);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {DIGITS{4'h9}};
    localparam logic [3:0]         LIFE_NIB  = 4'(LIFE_DIGIT);

    state_e               state_q, state_d;
    ev_code_e             mem_q [QDEPTH];
    ev_code_e             mem_d [QDEPTH];
    ev_code_e             req_s [3];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d, free_s, n_req_s, n_acc_s;
    logic                 pop_s, drop_s;
    logic [1:0]           combo_q, combo_d, combo_eff_s;
    ev_code_e             cur_code_q, cur_code_d;
    logic [SCORE_W-1:0]   addend_q, addend_d, work_q, work_d;
    logic [SCORE_W-1:0]   score_q, score_d, hi_q, hi_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 carry_q, carry_d, sat_q, sat_d, life_q, life_d;
    logic                 go_pend_q, go_pend_d, busy_q, busy_d;
    logic                 extra_life_q, extra_life_d, ovf_q, ovf_d;
    logic [3:0]           pre_thou_q, pre_thou_d;
    logic [3:0]           dig_a_s, dig_b_s, dig_sum_s;
    logic                 dig_cout_s;

    assign pop_s   = (state_q == ST_IDLE) && (count_q != {CNT_W{1'b0}});
    assign dig_a_s = score_q[{idx_q, 2'b00} +: 4];
    assign dig_b_s = addend_q[{idx_q, 2'b00} +: 4];

    pacman_score_keeper_bcd_digit_add u_digit_add (
        .a    (dig_a_s),
        .b    (dig_b_s),
        .cin  (carry_q),
        .sum  (dig_sum_s),
        .cout (dig_cout_s)
    );

    // Event acceptance: compact simultaneous pulses into power, ghost, pellet order.
    always_comb begin
        mem_d       = mem_q;
        req_s[0]    = EV_PELLET;
        req_s[1]    = EV_PELLET;
        req_s[2]    = EV_PELLET;
        n_req_s     = {CNT_W{1'b0}};
        combo_eff_s = sk.power_eaten ? 2'd0 : combo_q;
        if (sk.power_eaten) begin
            req_s[n_req_s[1:0]] = EV_POWER;
            n_req_s             = n_req_s + CNT_W'(1);
        end else begin
            n_req_s = n_req_s;
        end
        if (sk.ghost_eaten) begin
            req_s[n_req_s[1:0]] = ghost_code(combo_eff_s);
            n_req_s             = n_req_s + CNT_W'(1);
        end else begin
            n_req_s = n_req_s;
        end
        if (sk.pellet_eaten) begin
            req_s[n_req_s[1:0]] = EV_PELLET;
            n_req_s             = n_req_s + CNT_W'(1);
        end else begin
            n_req_s = n_req_s;
        end
        // A pop in the same cycle frees its slot for an incoming entry.
        free_s  = CNT_W'(QDEPTH) - count_q + CNT_W'(pop_s);
        drop_s  = (n_req_s > free_s);
        n_acc_s = drop_s ? free_s : n_req_s;
        for (int k = 0; k < 3; k++) begin
            mem_d[wr_ptr_q + PTR_W'(k)] = (CNT_W'(k) < n_acc_s) ? req_s[k]
                                                                 : mem_d[wr_ptr_q + PTR_W'(k)];
        end
        if (sk.game_start) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
            ovf_d    = 1'b0;
            combo_d  = 2'd0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(n_acc_s);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
            count_d  = count_q + n_acc_s - CNT_W'(pop_s);
            ovf_d    = ovf_q | drop_s;
            combo_d  = sk.ghost_eaten ? combo_next(combo_eff_s) : combo_eff_s;
        end
    end

    // Scoring FSM: pop, build addend, ripple one digit per cycle, check life threshold.
    always_comb begin
        state_d      = state_q;
        cur_code_d   = cur_code_q;
        addend_d     = addend_q;
        work_d       = work_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        sat_d        = sat_q;
        pre_thou_d   = pre_thou_q;
        life_d       = life_q;
        score_d      = score_q;
        hi_d         = hi_q;
        extra_life_d = 1'b0;
        go_pend_d    = go_pend_q | sk.game_over;
        if (!sk.game_start) begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        cur_code_d = mem_q[rd_ptr_q];
                        state_d    = ST_LOAD;
                    end else if (go_pend_q) begin
                        hi_d      = (score_q > hi_q) ? score_q : hi_q;
                        go_pend_d = sk.game_over;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    addend_d = SCORE_W'(points_bcd(cur_code_q));
                    work_d   = {SCORE_W{1'b0}};
                    idx_d    = {IDX_W{1'b0}};
                    carry_d  = 1'b0;
                    state_d  = ST_ADD;
                end
                ST_ADD: begin
                    work_d[{idx_q, 2'b00} +: 4] = dig_sum_s;
                    carry_d                     = dig_cout_s;
                    if (idx_q == IDX_W'(DIGITS - 1)) begin
                        idx_d      = {IDX_W{1'b0}};
                        pre_thou_d = score_q[SCORE_W-1 -: 4];
                        sat_d      = dig_cout_s;
                        score_d    = dig_cout_s ? SCORE_MAX : work_d;
                        state_d    = ST_CHECK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (!life_q && (pre_thou_q < LIFE_NIB) &&
                        ((score_q[SCORE_W-1 -: 4] >= LIFE_NIB) || sat_q)) begin
                        extra_life_d = 1'b1;
                        life_d       = 1'b1;
                    end else begin
                        extra_life_d = 1'b0;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d   = ST_IDLE;
            score_d   = {SCORE_W{1'b0}};
            life_d    = 1'b0;
            go_pend_d = 1'b0;
            idx_d     = {IDX_W{1'b0}};
            carry_d   = 1'b0;
            sat_d     = 1'b0;
        end
    end

    // Busy reflects the state being entered so the output register is exact.
    always_comb begin
        busy_d = (count_d != {CNT_W{1'b0}}) || (state_d != ST_IDLE) || go_pend_d;
    end

    // State and output registers.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= EV_PELLET;
            end
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            combo_q      <= 2'd0;
            cur_code_q   <= EV_PELLET;
            addend_q     <= {SCORE_W{1'b0}};
            work_q       <= {SCORE_W{1'b0}};
            score_q      <= {SCORE_W{1'b0}};
            hi_q         <= {SCORE_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            carry_q      <= 1'b0;
            sat_q        <= 1'b0;
            life_q       <= 1'b0;
            go_pend_q    <= 1'b0;
            busy_q       <= 1'b0;
            extra_life_q <= 1'b0;
            ovf_q        <= 1'b0;
            pre_thou_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            combo_q      <= combo_d;
            cur_code_q   <= cur_code_d;
            addend_q     <= addend_d;
            work_q       <= work_d;
            score_q      <= score_d;
            hi_q         <= hi_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            sat_q        <= sat_d;
            life_q       <= life_d;
            go_pend_q    <= go_pend_d;
            busy_q       <= busy_d;
            extra_life_q <= extra_life_d;
            ovf_q        <= ovf_d;
            pre_thou_q   <= pre_thou_d;
        end
    end

    assign sk.score_bcd  = score_q;
    assign sk.hi_bcd     = hi_q;
    assign sk.busy       = busy_q;
    assign sk.extra_life = extra_life_q;
    assign sk.q_overflow = ovf_q;

endmodule
